// File: rtl/series_job_dispatcher.sv
// Job FIFO plus single-job issue FSM in front of the series evaluator engine.
// Each accepted job gets exactly one tagged response, returned in FIFO order.
module series_job_dispatcher #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [7:0]       req_x,
  input  logic [2:0]       req_n,
  input  logic [TAG_W-1:0] req_tag,
  output logic             eng_start,
  output logic [7:0]       eng_x,
  output logic [2:0]       eng_n,
  input  logic             eng_valid,
  input  logic [31:0]      eng_result,
  input  logic             eng_overflow,
  input  logic             eng_error,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic [1:0]       rsp_status,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = 8 + 3 + TAG_W;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_e;
  typedef enum logic [1:0] {ST_OK = 2'b00, ST_OVF = 2'b01, ST_ERR = 2'b10, ST_TMO = 2'b11} status_e;

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [ENT_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  state_e           state_q, state_d;
  logic [7:0]       x_q, x_d;
  logic [2:0]       n_q, n_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;
  logic [15:0]      tmo_q, tmo_d;
  logic [31:0]      result_q, result_d;
  status_e          status_q, status_d;

  logic             push, pop, fifo_empty;
  logic             ovf_now, err_now, tmo_hit;
  logic [ENT_W-1:0] head;

  // Ready depends only on the registered count, never on this cycle's pop.
  assign req_ready = (count_q != CNT_W'(DEPTH));

  always_comb begin
    fifo_empty = (count_q == '0);
    push       = req_valid && req_ready;
    pop        = (state_q == S_IDLE) && !fifo_empty;
    head       = mem_q[rd_ptr_q];
    mem_d      = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = {req_x, req_n, req_tag};
    end
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    n_d      = n_q;
    tag_d    = tag_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    tmo_d    = tmo_q;
    result_d = result_q;
    status_d = status_q;
    // Flags arriving in the capture cycle still count toward the status.
    ovf_now  = ovf_q | eng_overflow;
    err_now  = err_q | eng_error;
    tmo_hit  = ((tmo_q + 16'd1) == 16'(TIMEOUT));
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          {x_d, n_d, tag_d} = head;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        ovf_d   = 1'b0;
        err_d   = 1'b0;
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        ovf_d = ovf_now;
        err_d = err_now;
        tmo_d = tmo_q + 16'd1;
        if (eng_valid) begin
          result_d = err_now ? '0 : eng_result;
          status_d = err_now ? ST_ERR : (ovf_now ? ST_OVF : ST_OK);
          state_d  = S_RESP;
        end else if (tmo_hit) begin
          result_d = '0;
          status_d = ST_TMO;
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= S_IDLE;
      x_q      <= '0;
      n_q      <= '0;
      tag_q    <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      tmo_q    <= '0;
      result_q <= '0;
      status_q <= ST_OK;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      x_q      <= x_d;
      n_q      <= n_d;
      tag_q    <= tag_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
      result_q <= result_d;
      status_q <= status_d;
    end
  end

  assign eng_start  = (state_q == S_LAUNCH);
  assign eng_x      = x_q;
  assign eng_n      = n_q;
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_result = result_q;
  assign rsp_status = status_q;
  assign rsp_tag    = tag_q;
  assign busy       = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_series_job_dispatcher.sv
// Directed bench for series_job_dispatcher; the engine is modelled inline by the stimulus.
module tb_series_job_dispatcher;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_x;
  logic [2:0]  req_n;
  logic [3:0]  req_tag;
  logic        eng_start;
  logic [7:0]  eng_x;
  logic [2:0]  eng_n;
  logic        eng_valid;
  logic [31:0] eng_result;
  logic        eng_overflow;
  logic        eng_error;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [1:0]  rsp_status;
  logic [3:0]  rsp_tag;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int start_cnt = 0;
  int b2b_cnt = 0;
  logic prev_start = 1'b0;

  series_job_dispatcher #(.DEPTH(4), .TAG_W(4), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_n(req_n), .req_tag(req_tag),
    .eng_start(eng_start), .eng_x(eng_x), .eng_n(eng_n),
    .eng_valid(eng_valid), .eng_result(eng_result), .eng_overflow(eng_overflow), .eng_error(eng_error),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_status(rsp_status),
    .rsp_tag(rsp_tag), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (eng_start) start_cnt++;
    if (eng_start && prev_start) b2b_cnt++;
    prev_start = eng_start;
  end

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] tag, input logic [7:0] x, input logic [2:0] n);
    req_valid = 1'b1;
    req_tag   = tag;
    req_x     = x;
    req_n     = n;
    step();
    req_valid = 1'b0;
  endtask

  // Waits for the job's start, answers after lat WAIT cycles, checks and retires the response.
  task automatic serve(input logic [3:0] tag, input logic [7:0] x, input logic [2:0] n,
                       input logic [31:0] res, input int lat, input int ovf_at, input int err_at,
                       input logic [1:0] st, input logic [31:0] exp_res, input int hold);
    int t = 0;
    while (eng_start !== 1'b1 && t < 20) begin
      step();
      t++;
    end
    chk("start_seen", eng_start, 1);
    chk("eng_x", eng_x, x);
    chk("eng_n", eng_n, n);
    for (int c = 1; c <= lat; c++) begin
      step();
      eng_overflow = (c == ovf_at);
      eng_error    = (c == err_at);
      eng_valid    = (c == lat);
      eng_result   = (c == lat) ? res : 32'hDEAD_BEEF;
    end
    step();
    eng_overflow = 1'b0;
    eng_error    = 1'b0;
    eng_valid    = 1'b0;
    eng_result   = '0;
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_status", rsp_status, st);
    chk("rsp_result", rsp_result, exp_res);
    chk("rsp_tag", rsp_tag, tag);
    for (int h = 0; h < hold; h++) begin
      step();
      chk("hold_ctl", {rsp_valid, rsp_status, rsp_tag, eng_start}, {1'b1, st, tag, 1'b0});
      chk("hold_res", rsp_result, exp_res);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rsp_drop", rsp_valid, 0);
  endtask

  initial begin
    int s0;
    int rv;
    reset = 1'b0; req_valid = 1'b0; req_x = '0; req_n = '0; req_tag = '0;
    eng_valid = 1'b0; eng_result = '0; eng_overflow = 1'b0; eng_error = 1'b0; rsp_ready = 1'b0;
    repeat (3) step();
    chk("rst_ctl", {req_ready, eng_start, eng_x, eng_n, rsp_valid, rsp_status, rsp_tag, busy},
        {1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 2'b00, 4'h0, 1'b0});
    chk("rst_result", rsp_result, 0);
    reset = 1'b1;
    step();

    // Single job: start two cycles after push, answered 6 cycles after start
    s0 = start_cnt;
    push(4'd1, 8'h40, 3'd3);
    chk("lat_busy", busy, 1);
    chk("lat_nostart", eng_start, 0);
    step();
    chk("lat_start", eng_start, 1);
    serve(4'd1, 8'h40, 3'd3, 32'h0000_1234, 6, 0, 0, 2'b00, 32'h0000_1234, 0);
    chk("t1_start_once", start_cnt - s0, 1);
    chk("t1_idle", busy, 0);

    // Five back-to-back jobs, FIFO fills while job 0 is in flight
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1;
      req_tag   = 4'(i);
      req_x     = 8'h10 + 8'(i);
      req_n     = 3'(i);
      step();
    end
    req_tag = 4'd5; req_x = 8'hFF; req_n = 3'd7;
    chk("full_ready", req_ready, 0);
    step();
    req_valid = 1'b0;
    chk("full_ready2", req_ready, 0);
    chk("j0_x", eng_x, 8'h10);
    chk("j0_n", eng_n, 0);
    eng_valid = 1'b1; eng_result = 32'h0000_A000;
    step();
    eng_valid = 1'b0; eng_result = '0;
    chk("j0_rsp", {rsp_valid, rsp_status, rsp_tag}, {1'b1, 2'b00, 4'd0});
    chk("j0_res", rsp_result, 32'h0000_A000);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    for (int i = 1; i < 5; i++) begin
      serve(4'(i), 8'h10 + 8'(i), 3'(i), 32'h0000_A000 + 32'(i), 3, 0, 0, 2'b00,
            32'h0000_A000 + 32'(i), 0);
    end
    chk("t2_drained", busy, 0);

    // Sticky flags, priority, capture-cycle flags, valid coinciding with timeout
    push(4'd2, 8'h55, 3'd2);
    serve(4'd2, 8'h55, 3'd2, 32'hFFFF_0000, 5, 2, 0, 2'b01, 32'hFFFF_0000, 0);
    push(4'd3, 8'h56, 3'd1);
    serve(4'd3, 8'h56, 3'd1, 32'hFFFF_0000, 5, 2, 4, 2'b10, 32'h0000_0000, 0);
    push(4'd4, 8'h57, 3'd4);
    serve(4'd4, 8'h57, 3'd4, 32'h0BAD_F00D, 3, 3, 0, 2'b01, 32'h0BAD_F00D, 0);
    push(4'd5, 8'h58, 3'd5);
    serve(4'd5, 8'h58, 3'd5, 32'h1357_9BDF, 8, 0, 0, 2'b00, 32'h1357_9BDF, 0);

    // Timeout on the 8th WAIT cycle, then the queued job launches
    push(4'd6, 8'h66, 3'd6);
    push(4'd7, 8'h77, 3'd7);
    chk("t4_start", eng_start, 1);
    repeat (8) step();
    chk("tmo_not_early", rsp_valid, 0);
    step();
    chk("tmo_rsp", {rsp_valid, rsp_status, rsp_tag, eng_start}, {1'b1, 2'b11, 4'd6, 1'b0});
    chk("tmo_res", rsp_result, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    serve(4'd7, 8'h77, 3'd7, 32'h0000_0777, 2, 0, 0, 2'b00, 32'h0000_0777, 0);

    // Response backpressure for 10 cycles holds everything
    push(4'd8, 8'h88, 3'd0);
    push(4'd9, 8'h99, 3'd1);
    serve(4'd8, 8'h88, 3'd0, 32'h8888_0000, 4, 0, 0, 2'b00, 32'h8888_0000, 10);
    serve(4'd9, 8'h99, 3'd1, 32'h9999_0000, 4, 0, 0, 2'b00, 32'h9999_0000, 0);

    // Reset during WAIT with two jobs queued
    push(4'd10, 8'hA0, 3'd2);
    push(4'd11, 8'hB0, 3'd3);
    push(4'd12, 8'hC0, 3'd4);
    step();
    chk("t6_inflight", {busy, eng_x}, {1'b1, 8'hA0});
    reset = 1'b0;
    step();
    chk("t6_rst_ctl", {req_ready, eng_start, eng_x, eng_n, rsp_valid, rsp_status, rsp_tag, busy},
        {1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 2'b00, 4'h0, 1'b0});
    chk("t6_rst_res", rsp_result, 0);
    reset = 1'b1;
    s0 = start_cnt;
    rv = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (rsp_valid) rv++;
    end
    chk("t6_no_start", start_cnt - s0, 0);
    chk("t6_no_rsp", rv, 0);
    chk("t6_idle", busy, 0);

    chk("total_starts", start_cnt, 15);
    chk("no_b2b_start", b2b_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
